// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the writeback stage: major opcodes, load
// funct3 codes and the load-data formatting helper.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Data memory returns one word per address, so narrow loads always
    // take the low byte/halfword; there is no byte-lane shift.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word);
        case (f3)
            F3_LB:   return {{24{word[7]}}, word[7:0]};
            F3_LH:   return {{16{word[15]}}, word[15:0]};
            F3_LW:   return word;
            F3_LBU:  return {24'h0, word[7:0]};
            F3_LHU:  return {16'h0, word[15:0]};
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2w4r.sv
// Architectural register file: two write ports, four combinational read
// ports with write-through bypass. x0 is never written and reads as zero.
module regfile_2w4r #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we0_i,
    input  logic [AW-1:0]   waddr0_i,
    input  logic [XLEN-1:0] wdata0_i,
    input  logic            prio0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   waddr1_i,
    input  logic [XLEN-1:0] wdata1_i,
    input  logic            prio1_i,
    input  logic [AW-1:0]   raddr_i [4],
    output logic [XLEN-1:0] rdata_o [4]
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic            conflict;
    logic            lane0_wins;
    logic            we0_eff;
    logic            we1_eff;

    // Same-destination writes: lane 0 wins only when it alone is the younger;
    // a tie in prio goes to lane 1.
    always_comb begin
        conflict   = we0_i && we1_i && (waddr0_i == waddr1_i);
        lane0_wins = prio0_i && !prio1_i;
        we0_eff    = we0_i && (waddr0_i != '0) && (!conflict || lane0_wins);
        we1_eff    = we1_i && (waddr1_i != '0) && (!conflict || !lane0_wins);
    end

    // Storage; reset clears every entry immediately and drops any pending write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we0_eff) regs_q[waddr0_i] <= wdata0_i;
            if (we1_eff) regs_q[waddr1_i] <= wdata1_i;
        end
    end

    // Read ports: x0 and reset read zero, otherwise bypass the surviving write.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rdata_o[p] = '0;
            if (!rst_i && (raddr_i[p] != '0)) begin
                if (we1_eff && (waddr1_i == raddr_i[p])) begin
                    rdata_o[p] = wdata1_i;
                end else if (we0_eff && (waddr0_i == raddr_i[p])) begin
                    rdata_o[p] = wdata0_i;
                end else begin
                    rdata_o[p] = regs_q[raddr_i[p]];
                end
            end
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage of the dual-issue RV32I pipeline: per-lane result
// selection, register-file update and retired-instruction counting.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     instr_0_i,
    input  logic            reg_file_en_0_i,
    input  logic            mem_en_0_i,
    input  logic [XLEN-1:0] alu_out_0_i,
    input  logic [XLEN-1:0] pc_0_i,
    input  logic            prio_0_i,
    input  logic [XLEN-1:0] mem_data_adres_0_i,
    output logic [XLEN-1:0] load_adres_0_o,
    input  logic [XLEN-1:0] load_mem_data_0_i,
    output logic            wb_en_0_o,
    output logic [4:0]      wb_rd_0_o,
    output logic [XLEN-1:0] wb_data_0_o,
    input  logic [31:0]     instr_1_i,
    input  logic            reg_file_en_1_i,
    input  logic            mem_en_1_i,
    input  logic [XLEN-1:0] alu_out_1_i,
    input  logic [XLEN-1:0] pc_1_i,
    input  logic            prio_1_i,
    input  logic [XLEN-1:0] mem_data_adres_1_i,
    output logic [XLEN-1:0] load_adres_1_o,
    input  logic [XLEN-1:0] load_mem_data_1_i,
    output logic            wb_en_1_o,
    output logic [4:0]      wb_rd_1_o,
    output logic [XLEN-1:0] wb_data_1_o,
    input  logic [4:0]      rs1_0_i,
    input  logic [4:0]      rs2_0_i,
    input  logic [4:0]      rs1_1_i,
    input  logic [4:0]      rs2_1_i,
    output logic [XLEN-1:0] rs1_0_data_o,
    output logic [XLEN-1:0] rs2_0_data_o,
    output logic [XLEN-1:0] rs1_1_data_o,
    output logic [XLEN-1:0] rs2_1_data_o,
    output logic [63:0]     instret_o
);

    logic [63:0]     instret_q;
    logic [63:0]     instret_d;
    logic [4:0]      raddr [4];
    logic [XLEN-1:0] rdata [4];
    logic            unused_mem_en;

    // The memory-access flag carries no information this stage needs.
    assign unused_mem_en = &{1'b0, mem_en_0_i, mem_en_1_i};

    function automatic logic [XLEN-1:0] lane_result(
        input logic [31:0]     instr,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] mem
    );
        case (instr[6:0])
            OP_LOAD:          return load_ext(instr[14:12], mem);
            OP_JAL, OP_JALR:  return pc + XLEN'(4);
            default:          return alu;
        endcase
    endfunction

    // Per-lane result selection and write-enable qualification.
    always_comb begin
        load_adres_0_o = mem_data_adres_0_i;
        load_adres_1_o = mem_data_adres_1_i;
        wb_rd_0_o      = instr_0_i[11:7];
        wb_rd_1_o      = instr_1_i[11:7];
        wb_data_0_o    = lane_result(instr_0_i, alu_out_0_i, pc_0_i, load_mem_data_0_i);
        wb_data_1_o    = lane_result(instr_1_i, alu_out_1_i, pc_1_i, load_mem_data_1_i);
        wb_en_0_o      = reg_file_en_0_i && (instr_0_i[11:7] != 5'd0) && (instr_0_i != 32'd0);
        wb_en_1_o      = reg_file_en_1_i && (instr_1_i[11:7] != 5'd0) && (instr_1_i != 32'd0);
        raddr[0]       = rs1_0_i;
        raddr[1]       = rs2_0_i;
        raddr[2]       = rs1_1_i;
        raddr[3]       = rs2_1_i;
        rs1_0_data_o   = rdata[0];
        rs2_0_data_o   = rdata[1];
        rs1_1_data_o   = rdata[2];
        rs2_1_data_o   = rdata[3];
        instret_d      = instret_q + 64'(instr_0_i != 32'd0) + 64'(instr_1_i != 32'd0);
        instret_o      = instret_q;
    end

    // Retired-instruction counter, wraps naturally at 2^64.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) instret_q <= '0;
        else       instret_q <= instret_d;
    end

    regfile_2w4r #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (5)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we0_i    (wb_en_0_o),
        .waddr0_i (wb_rd_0_o),
        .wdata0_i (wb_data_0_o),
        .prio0_i  (prio_0_i),
        .we1_i    (wb_en_1_o),
        .waddr1_i (wb_rd_1_o),
        .wdata1_i (wb_data_1_o),
        .prio1_i  (prio_1_i),
        .raddr_i  (raddr),
        .rdata_o  (rdata)
    );

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the dual-issue RV32I pipeline. It consumes both lanes' memory-stage pipeline outputs and formats load data (LB/LH/LW/LBU/LHU). It owns the 32×32 architectural register file with two write ports and four bypassed read ports for decode, and it keeps a 64-bit retired-instruction counter. Same-destination conflicts between the two lanes resolve in favour of the younger lane.

## Interface
- Parameters:
  - XLEN, 32, datapath width
  - NUM_REGS, 32, register count; x0 hardwired to zero
- Ports (lane index n ∈ {0,1}):
  - clk_i  in  1  clock; all state updates on the rising edge
  - rst_i  in  1  asynchronous, active-high reset
  - instr_n_i  in  32  instruction from the memory stage; 0 marks a bubble
  - reg_file_en_n_i  in  1  instruction writes rd
  - mem_en_n_i  in  1  memory-access flag from the memory stage
  - alu_out_n_i  in  32  ALU result
  - pc_n_i  in  32  instruction PC
  - prio_n_i  in  1  lane holds the younger instruction of the pair
  - mem_data_adres_n_i  in  32  memory-stage data address
  - load_adres_n_o  out  32  load address driven to data memory; equals mem_data_adres_n_i
  - load_mem_data_n_i  in  32  word returned by data memory in the same cycle
  - wb_en_n_o  out  1  this lane writes a nonzero rd this cycle
  - wb_rd_n_o  out  5  destination register
  - wb_data_n_o  out  32  value being written; feeds the forwarding unit
  - rs1_n_i, rs2_n_i  in  5  decode read addresses
  - rs1_data_n_o, rs2_data_n_o  out  32  decode read data
  - instret_o  out  64  retired-instruction count

## Operation
- Opcode comes from instr[6:0]; funct3 from instr[14:12]; rd from instr[11:7].
- Result selection per lane (combinational):
  - Load (0000011): formats load_mem_data[7:0] or [15:0]. Memory is one word per address, so no byte-lane shift.
    - funct3 000: sign-extend byte
    - funct3 001: sign-extend halfword
    - funct3 010: full word
    - funct3 100: zero-extend byte
    - funct3 101: zero-extend halfword
    - any other funct3: 0
  - JAL (1101111) / JALR (1100111): pc + 4, modulo 2^32.
  - All other opcodes: alu_out.
- wb_en_n_o = reg_file_en_n_i && rd != 0 && instr != 0.
- Conflict rule: if both lanes write the same rd in one cycle, only the lane with prio=1 writes.
  - If prio is equal on both lanes, lane 1 wins.
  - The losing lane's wb_en_n_o still reads 1 (forwarding sees both), but its register-file write is suppressed.
- Register file:
  - Written on the rising edge.
  - x0 is never written and always reads 0.
- Read ports are combinational with write-through bypass.
  - If a read address matches an active write this cycle, the port returns the winning write data.
  - Otherwise it returns the stored value.
  - Address 0 always returns 0.
- instret_o increments each cycle by the count of lanes with instr != 0 (0, 1 or 2) and wraps at 2^64.

## Timing
- Result formatting and the wb_*, load_adres and read-data outputs are combinational; zero latency from inputs.
- A register write is visible in storage one edge later; the bypass makes it visible in the same cycle.
- Reset, applied at any time including mid-stream:
  - all 31 registers and instret_o clear to 0 immediately, with no clock needed;
  - a write scheduled for the edge coinciding with reset assertion is lost;
  - while reset is held, all read outputs return 0;
  - combinational outputs follow the inputs.
- Release of reset:
  - the first edge with rst_i low performs normal writes;
  - instret_o counts from 0.

## Structure
- Opcode constants (OP_LOAD, OP_JAL, OP_JALR) and load funct3 codes belong in riscv_pkg.
- The load-extension function also belongs in riscv_pkg.
- One sub-module, regfile_2w4r, holds storage, the write-conflict rule and the bypass.
- writeback_stage holds per-lane result muxing and instret.

## Test plan
- Lane 0 LB (funct3 000), rd=5, load word 0x0000_0080 → wb_data_0_o = 0xFFFF_FF80; next cycle rs1_0_i=5 reads 0xFFFF_FF80. Repeat with LBU → 0x0000_0080.
- Lane 1 JAL at pc 0x0000_0FFC, rd=1 → x1 = 0x0000_1000. Repeat at pc 0xFFFF_FFFC → x1 = 0x0000_0000.
- Both lanes write rd=7 (lane 0 = 0x11 with prio=1, lane 1 = 0x22 with prio=0) → x7 = 0x11. Swap prio → x7 = 0x22. Equal prio → x7 = 0x22.
- Lane 0 writes x3 = 0xDEAD_BEEF while rs2_1_i=3 in the same cycle → rs2_1_data_o = 0xDEAD_BEEF combinationally. A write to rd=0 leaves x0 reading 0.
- Ten cycles with two valid lanes, then three cycles with lane 1 instr=0 → instret_o = 23. Assert rst_i between edges → instret_o and all registers read 0 before the next edge.
- Reset asserted coincident with a pending write of x9 = 0x55 → x9 reads 0 after release. The first post-reset write to x9 lands normally.
